// File: rtl/boot_sequencer.sv
// boot_sequencer: owns the UART rx byte stream. LOAD packs big-endian 32-bit words
// into instruction memory until an all-ones terminator word, then RUN feeds bytes
// to the core through a first-word-fall-through FIFO.
// Optional feature macro CHECKSUM_BOOT_EN: after the terminator a CHECK state
// compares one extra byte against the XOR of all loaded program bytes.
module boot_sequencer #(
    parameter int MEM_INST_SIZE = 1024,
    parameter int FIFO_DEPTH    = 16
) (
    input  logic                             CLK,
    input  logic                             RST,
    input  logic [7:0]                       rx_data,
    input  logic                             rx_valid,
    output logic                             imem_we,
    output logic [$clog2(MEM_INST_SIZE)-1:0] imem_addr,
    output logic [31:0]                      imem_wdata,
    output logic                             boot_done,
    output logic [$clog2(MEM_INST_SIZE):0]   prog_len,
    input  logic                             in_rd,
    output logic [7:0]                       in_data,
    output logic                             in_empty,
    output logic [1:0]                       err
);
    localparam int AW = $clog2(MEM_INST_SIZE);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] MAX_LEN = (AW+1)'(MEM_INST_SIZE);
    localparam logic [PW:0] FULL = (PW+1)'(FIFO_DEPTH);

`ifdef CHECKSUM_BOOT_EN
    typedef enum logic [1:0] {S_LOAD, S_CHECK, S_RUN, S_ERR} state_t;
`else
    typedef enum logic [1:0] {S_LOAD, S_RUN, S_ERR} state_t;
`endif

    state_t state, state_n;
    logic [1:0] byte_idx;
    logic [31:0] word, word_n;
    logic [1:0] err_n;
    logic wr;

    logic [7:0] fifo [FIFO_DEPTH];
    logic [PW-1:0] wp, rp;
    logic [PW:0] cnt;
    logic push, pop;

    assign pop = in_rd && cnt != '0;
    assign push = state == S_RUN && rx_valid && (cnt != FULL || pop);
    assign in_empty = cnt == '0;
    assign in_data = in_empty ? 8'h00 : fifo[rp];
    assign imem_wdata = word;

`ifdef CHECKSUM_BOOT_EN
    logic [7:0] csum;

    // Terminator bytes XOR to zero, so folding every LOAD byte equals excluding them.
    always_ff @(posedge CLK) begin
        if (RST) csum <= 8'h00;
        else if (state == S_LOAD && rx_valid) csum <= csum ^ rx_data;
    end
`endif

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) state <= S_LOAD;
        else state <= state_n;
    end

    // Next state, write strobe and sticky error code from the incoming byte.
    always_comb begin
        state_n = state;
        err_n = err;
        wr = 1'b0;
        word_n = {word[23:0], rx_data};
        case (state)
            S_LOAD: begin
                if (rx_valid && &byte_idx) begin
                    if (&word_n) begin
`ifdef CHECKSUM_BOOT_EN
                        state_n = S_CHECK;
`else
                        state_n = S_RUN;
`endif
                    end else if (prog_len == MAX_LEN) begin
                        state_n = S_ERR;
                        err_n = 2'd1;
                    end else begin
                        wr = 1'b1;
                    end
                end
            end
`ifdef CHECKSUM_BOOT_EN
            S_CHECK: begin
                if (rx_valid) begin
                    state_n = rx_data == csum ? S_RUN : S_ERR;
                    err_n = rx_data == csum ? err : 2'd3;
                end
            end
`endif
            S_RUN: err_n = rx_valid && cnt == FULL && !pop ? 2'd2 : err;
            default: ;
        endcase
    end

    // Word assembly, imem write port and boot status.
    always_ff @(posedge CLK) begin
        if (RST) begin
            byte_idx <= 2'd0;
            word <= 32'h0;
            imem_we <= 1'b0;
            imem_addr <= '0;
            prog_len <= '0;
            boot_done <= 1'b0;
            err <= 2'd0;
        end else begin
            imem_we <= wr;
            err <= err_n;
            boot_done <= boot_done | (state_n == S_RUN);
            if (state == S_LOAD && rx_valid) begin
                byte_idx <= byte_idx + 2'd1;
                word <= word_n;
            end
            if (wr) begin
                imem_addr <= prog_len[AW-1:0];
                prog_len <= prog_len + (AW+1)'(1);
            end
        end
    end

    // FIFO storage; contents need no reset because in_data is masked while empty.
    always_ff @(posedge CLK) begin
        if (push) fifo[wp] <= rx_data;
    end

    // FIFO pointers and occupancy; a simultaneous push and pop leaves cnt unchanged.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wp <= '0;
            rp <= '0;
            cnt <= '0;
        end else begin
            if (push) wp <= wp + PW'(1);
            if (pop) rp <= rp + PW'(1);
            cnt <= cnt + (PW+1)'(push) - (PW+1)'(pop);
        end
    end
endmodule

// File: tb/tb_boot_sequencer.sv
// tb_boot_sequencer: randomized bench checking boot_sequencer every cycle against a
// queue-based reference model, plus hand-computed literal expectations.
module tb_boot_sequencer;
    localparam int MIS = 4;
    localparam int FD = 8;
    localparam int AW = $clog2(MIS);

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic rx_valid = 1'b0;
    logic in_rd = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0] imem_wdata;
    logic boot_done;
    logic [AW:0] prog_len;
    logic [7:0] in_data;
    logic in_empty;
    logic [1:0] err;

    boot_sequencer #(.MEM_INST_SIZE(MIS), .FIFO_DEPTH(FD)) dut (
        .CLK(CLK), .RST(RST), .rx_data(rx_data), .rx_valid(rx_valid),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .boot_done(boot_done), .prog_len(prog_len), .in_rd(in_rd),
        .in_data(in_data), .in_empty(in_empty), .err(err)
    );

    always #5 CLK = ~CLK;

    int n_pass = 0;
    int n_total = 0;
    bit chk_en = 1'b0;

    // Reference model: phase 0 load, 1 check, 2 run, 3 error.
    int phase = 0;
    logic [7:0] part[$];
    logic [7:0] q[$];
    int m_len = 0;
    logic [1:0] m_err = 2'd0;
    logic m_done = 1'b0;
    logic m_we = 1'b0;
    int m_addr = 0;
    logic [31:0] m_wdata = 32'h0;
    logic [7:0] m_xs = 8'h00;

    int wa[$];
    logic [31:0] wd[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    endtask

    task automatic model_step();
        int ph;
        logic [31:0] w;
        logic do_pop;
        m_we = 1'b0;
        if (RST) begin
            phase = 0;
            part.delete();
            q.delete();
            m_len = 0;
            m_err = 2'd0;
            m_done = 1'b0;
            m_xs = 8'h00;
            return;
        end
        ph = phase;
        do_pop = in_rd && q.size() > 0;
        if (ph == 2 && rx_valid) begin
            if (q.size() == FD && !do_pop) m_err = 2'd2;
            else q.push_back(rx_data);
        end
        if (do_pop) void'(q.pop_front());
        if (ph == 0 && rx_valid) begin
            part.push_back(rx_data);
            if (part.size() == 4) begin
                w = {part[0], part[1], part[2], part[3]};
                part.delete();
                if (w == 32'hFFFF_FFFF) begin
`ifdef CHECKSUM_BOOT_EN
                    phase = 1;
`else
                    phase = 2;
                    m_done = 1'b1;
`endif
                end else if (m_len == MIS) begin
                    m_err = 2'd1;
                    phase = 3;
                end else begin
                    m_we = 1'b1;
                    m_addr = m_len;
                    m_wdata = w;
                    m_len++;
                    m_xs = m_xs ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
                end
            end
        end
`ifdef CHECKSUM_BOOT_EN
        if (ph == 1 && rx_valid) begin
            if (rx_data == m_xs) begin
                phase = 2;
                m_done = 1'b1;
            end else begin
                m_err = 2'd3;
                phase = 3;
            end
        end
`endif
    endtask

    always @(negedge CLK) begin
        if (chk_en) begin
            chk("imem_we", 32'(imem_we), 32'(m_we));
            if (m_we) begin
                chk("imem_addr", 32'(imem_addr), 32'(m_addr));
                chk("imem_wdata", imem_wdata, m_wdata);
            end
            chk("boot_done", 32'(boot_done), 32'(m_done));
            chk("prog_len", 32'(prog_len), 32'(m_len));
            chk("in_empty", 32'(in_empty), 32'(q.size() == 0));
            chk("in_data", 32'(in_data), q.size() > 0 ? 32'(q[0]) : 32'd0);
            chk("err", 32'(err), 32'(m_err));
        end
    end

    always @(negedge CLK) begin
        if (imem_we) begin
            wa.push_back(int'(imem_addr));
            wd.push_back(imem_wdata);
        end
    end

    task automatic tick(input logic v, input logic [7:0] d, input logic rd);
        rx_valid = v;
        rx_data = d;
        in_rd = rd;
        @(posedge CLK);
        model_step();
        @(negedge CLK);
        rx_valid = 1'b0;
        in_rd = 1'b0;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        tick(1'b0, 8'h00, 1'b0);
        RST = 1'b0;
        wa.delete();
        wd.delete();
    endtask

    task automatic send_word(input logic [31:0] w);
        tick(1'b1, w[31:24], 1'b0);
        tick(1'b1, w[23:16], 1'b0);
        tick(1'b1, w[15:8], 1'b0);
        tick(1'b1, w[7:0], 1'b0);
    endtask

    task automatic send_term();
        send_word(32'hFFFF_FFFF);
`ifdef CHECKSUM_BOOT_EN
        tick(1'b1, m_xs, 1'b0);
`endif
    endtask

    initial begin
        chk_en = 1'b1;
        do_reset();
        chk("rst_imem_we", 32'(imem_we), 32'd0);
        chk("rst_imem_addr", 32'(imem_addr), 32'd0);
        chk("rst_boot_done", 32'(boot_done), 32'd0);
        chk("rst_in_empty", 32'(in_empty), 32'd1);
        chk("rst_in_data", 32'(in_data), 32'd0);
        chk("rst_err", 32'(err), 32'd0);

        send_word(32'h0011_2233);
        send_term();
        chk("s1_boot_done", 32'(boot_done), 32'd1);
        tick(1'b0, 8'h00, 1'b0);
        chk("s1_nwrites", 32'(wa.size()), 32'd1);
        chk("s1_addr", 32'(wa[0]), 32'd0);
        chk("s1_data", wd[0], 32'h0011_2233);
        chk("s1_prog_len", 32'(prog_len), 32'd1);

        do_reset();
        send_word(32'h0102_0304);
        send_word(32'h0506_0708);
        send_term();
        tick(1'b0, 8'h00, 1'b0);
        chk("s2_nwrites", 32'(wa.size()), 32'd2);
        chk("s2_data0", wd[0], 32'h0102_0304);
        chk("s2_addr1", 32'(wa[1]), 32'd1);
        chk("s2_data1", wd[1], 32'h0506_0708);

        tick(1'b1, 8'hAA, 1'b0);
        tick(1'b1, 8'hBB, 1'b0);
        chk("s3_head", 32'(in_data), 32'hAA);
        tick(1'b0, 8'h00, 1'b1);
        chk("s3_next", 32'(in_data), 32'hBB);
        chk("s3_nonempty", 32'(in_empty), 32'd0);
        tick(1'b0, 8'h00, 1'b1);
        chk("s3_empty", 32'(in_empty), 32'd1);
        tick(1'b0, 8'h00, 1'b1);
        chk("s3_empty_rd", 32'(in_empty), 32'd1);
        chk("s3_empty_data", 32'(in_data), 32'd0);
        chk("s3_err", 32'(err), 32'd0);

        for (int i = 0; i < FD; i++) tick(1'b1, 8'(8'h10 + i), 1'b0);
        chk("s4_full_err", 32'(err), 32'd0);
        tick(1'b1, 8'hEE, 1'b0);
        chk("s4_overrun_err", 32'(err), 32'd2);
        chk("s4_head", 32'(in_data), 32'h10);
        tick(1'b1, 8'hDD, 1'b1);
        chk("s4_pushpop_head", 32'(in_data), 32'h11);
        chk("s4_pushpop_err", 32'(err), 32'd2);
        for (int i = 0; i < FD; i++) tick(1'b0, 8'h00, 1'b1);
        chk("s4_drained", 32'(in_empty), 32'd1);

        do_reset();
        for (int i = 0; i < 5; i++) send_word({4{8'(i + 1)}});
        tick(1'b0, 8'h00, 1'b0);
        chk("s5_nwrites", 32'(wa.size()), 32'd4);
        chk("s5_err", 32'(err), 32'd1);
        chk("s5_boot_done", 32'(boot_done), 32'd0);
        send_term();
        chk("s5_stuck", 32'(boot_done), 32'd0);

        do_reset();
        tick(1'b1, 8'hAA, 1'b0);
        tick(1'b1, 8'hBB, 1'b0);
        do_reset();
        send_word(32'h0405_0607);
        send_term();
        tick(1'b0, 8'h00, 1'b0);
        chk("s6_nwrites", 32'(wa.size()), 32'd1);
        chk("s6_data", wd[0], 32'h0405_0607);

`ifdef CHECKSUM_BOOT_EN
        do_reset();
        send_word(32'h0011_2233);
        send_word(32'hFFFF_FFFF);
        tick(1'b1, 8'h00, 1'b0);
        chk("cs_ok_done", 32'(boot_done), 32'd1);
        do_reset();
        send_word(32'h0011_2233);
        send_word(32'hFFFF_FFFF);
        tick(1'b1, 8'h01, 1'b0);
        chk("cs_bad_err", 32'(err), 32'd3);
        chk("cs_bad_done", 32'(boot_done), 32'd0);
`endif

        for (int it = 0; it < 30; it++) begin
            int nw;
            do_reset();
            if ($urandom_range(0, 3) == 0) begin
                tick(1'b1, 8'($urandom), 1'b0);
                do_reset();
            end
            nw = $urandom_range(0, 5);
            for (int k = 0; k < nw; k++) begin
                logic [31:0] w;
                w = $urandom;
                if ($urandom_range(0, 3) == 0) w[31:8] = 24'hFF_FFFF;
                if (&w) w[0] = 1'b0;
                for (int b = 3; b >= 0; b--) begin
                    tick(1'b1, w[b*8 +: 8], $urandom_range(0, 1) == 1);
                    if ($urandom_range(0, 2) == 0) tick(1'b0, 8'h00, 1'b0);
                end
            end
            send_word(32'hFFFF_FFFF);
`ifdef CHECKSUM_BOOT_EN
            tick(1'b1, $urandom_range(0, 3) == 0 ? 8'($urandom) : m_xs, 1'b0);
`endif
            for (int c = 0; c < 60; c++)
                tick($urandom_range(0, 2) != 0, 8'($urandom), $urandom_range(0, 2) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
